// File: rtl/common_params.sv
// Shared parameters and types for the boot loader slice.
// Optional feature: define BOOT_CHECKSUM_EN to add the CHK state and the
// modulo-256 data byte checksum.
package common_params;

    localparam int ADDRIW     = 10;
    localparam int BITS       = 32;
    localparam int BOOT_LEN_W = 16;

    // Largest legal word count: one full I-MEM image.
    localparam logic [BOOT_LEN_W:0] MAX_WORDS = (BOOT_LEN_W+1)'(1 << ADDRIW);

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
`ifdef BOOT_CHECKSUM_EN
        CHK    = 3'd3,
`endif
        DONE   = 3'd4,
        ERR    = 3'd5
    } boot_state_t;

    // True when a requested load would overrun the instruction memory.
    function automatic logic len_too_big(input logic [BOOT_LEN_W-1:0] n);
        return ({1'b0, n} > MAX_WORDS);
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word accumulator for the boot loader.
// Bytes shift in from the top so the first byte ends up in bits 7:0.
// word_valid/word_out are combinational and describe the word completed by
// the byte accepted this cycle.
module boot_word_asm
    import common_params::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            byte_valid,
    input  logic [7:0]      byte_in,
    output logic [BITS-1:0] word_out,
    output logic            word_valid
);

    logic [BITS-1:0] acc_q, acc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [BITS-1:0] shifted;

    // Shift the incoming byte in and count bytes; clear wins over a byte.
    always_comb begin
        shifted = {byte_in, acc_q[BITS-1:8]};
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (byte_valid) begin
            acc_d = shifted;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Accumulator and byte counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_out   = shifted;
    assign word_valid = byte_valid && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/boot_ctrl.sv
// Boot loader: receives a little-endian word count followed by instruction
// bytes and writes the assembled words into I-MEM from address 0.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing checksum
// byte equal to the modulo-256 sum of all data bytes.
module boot_ctrl
    import common_params::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              boot_req,
    output logic [BITS-1:0]   wdata_data,
    output logic [ADDRIW-1:0] wdata_addr,
    output logic              we_boot,
    output logic              bootloading,
    output logic              boot_done,
    output logic              boot_err
);

    boot_state_t           state_q, state_d;
    logic [BOOT_LEN_W-1:0] len_q, len_d;
    logic [ADDRIW-1:0]     addr_q, addr_d;
    logic [BITS-1:0]       wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  last_q, last_d;
    logic                  bootloading_q, bootloading_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic                  asm_clear;
    logic                  data_accept;
    logic                  final_write;
    logic                  word_valid;
    logic [BITS-1:0]       word;
    logic [BOOT_LEN_W-1:0] len_full;
    logic [BOOT_LEN_W:0]   words_after;

    boot_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (data_accept),
        .byte_in    (rx_data),
        .word_out   (word),
        .word_valid (word_valid)
    );

    // Next-state and datapath updates; the write pulse of the last word is
    // still issued in DATA and the load finishes when that pulse ends.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        last_d      = last_q;
        asm_clear   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        final_write = we_q && last_q;
        data_accept = rx_valid && (state_q == DATA) && !final_write;
        len_full    = {rx_data, len_q[7:0]};
        words_after = (BOOT_LEN_W+1)'(addr_q) + 1'b1;

        case (state_q)
            LEN_LO: begin
                if (rx_valid) begin
                    len_d   = {8'h00, rx_data};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d  = len_full;
                    last_d = 1'b0;
                    if (len_full == '0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else if (len_too_big(len_full)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (we_q) begin
                    addr_d = addr_q + 1'b1;
                end
                if (word_valid) begin
                    wdata_d = word;
                    we_d    = 1'b1;
                    last_d  = (words_after == {1'b0, len_q});
                end
`ifdef BOOT_CHECKSUM_EN
                if (data_accept) begin
                    sum_d = sum_q + rx_data;
                end
                if (final_write) begin
                    if (rx_valid) begin
                        state_d = (rx_data == sum_q) ? DONE : ERR;
                    end else begin
                        state_d = CHK;
                    end
                end
`else
                if (final_write) begin
                    state_d = DONE;
                end
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            CHK: begin
                if (rx_valid) begin
                    state_d = (rx_data == sum_q) ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (boot_req) begin
                    state_d   = LEN_LO;
                    len_d     = '0;
                    addr_d    = '0;
                    last_d    = 1'b0;
                    asm_clear = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    sum_d     = '0;
`endif
                end
            end
            default: begin
                state_d = LEN_LO;
            end
        endcase

        bootloading_d = (state_d != DONE);
        done_d        = (state_d == DONE);
        err_d         = (state_d == ERR);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LEN_LO;
            len_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            last_q        <= 1'b0;
            bootloading_q <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            last_q        <= last_d;
            bootloading_q <= bootloading_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running modulo-256 sum of the data bytes of the current load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    assign wdata_data  = wdata_q;
    assign wdata_addr  = addr_q;
    assign we_boot     = we_q;
    assign bootloading = bootloading_q;
    assign boot_done   = done_q;
    assign boot_err    = err_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl.
// Honours BOOT_CHECKSUM_EN: when defined, every accepted load is followed by a
// checksum byte and the checksum scenarios are included.
module tb_boot_ctrl;
    import common_params::*;

    localparam int MAXW = 1 << ADDRIW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              boot_req = 1'b0;
    logic [BITS-1:0]   wdata_data;
    logic [ADDRIW-1:0] wdata_addr;
    logic              we_boot;
    logic              bootloading;
    logic              boot_done;
    logic              boot_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          we_double = 0;
    int          we_outside = 0;
    logic        prev_we = 1'b0;

    boot_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .boot_req    (boot_req),
        .wdata_data  (wdata_data),
        .wdata_addr  (wdata_addr),
        .we_boot     (we_boot),
        .bootloading (bootloading),
        .boot_done   (boot_done),
        .boot_err    (boot_err)
    );

    always #5 clk = ~clk;

    // Record every write pulse, and flag back-to-back or post-load pulses.
    always @(negedge clk) begin
        if (we_boot) begin
            obs_addr.push_back(32'(wdata_addr));
            obs_data.push_back(wdata_data);
            if (prev_we) we_double++;
            if (boot_done || boot_err) we_outside++;
        end
        prev_we = we_boot;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one cycle; caller is positioned at a negedge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
    endtask

    task automatic restart(input string tag, input bit with_byte);
        boot_req = 1'b1;
        if (with_byte) begin
            rx_valid = 1'b1;
            rx_data  = 8'h55;
        end
        @(negedge clk);
        boot_req = 1'b0;
        rx_valid = 1'b0;
        check_output({tag, "_bootloading"}, 32'(bootloading), 32'd1);
        check_output({tag, "_done_clr"}, 32'(boot_done), 32'd0);
        check_output({tag, "_err_clr"}, 32'(boot_err), 32'd0);
    endtask

    // Send a complete load and compare against the expected image and status.
    task automatic do_load(input string tag, input int n, input logic [7:0] payload[$],
                           input bit corrupt, input int max_gap);
        logic [31:0] exp_data[$];
        logic [7:0]  sum;
        bit          exp_err;
        int          waited;
        obs_addr.delete();
        obs_data.delete();
        exp_err = (n > MAXW);
        sum = 8'h00;
        if (!exp_err) begin
            for (int i = 0; i < n; i++)
                exp_data.push_back({payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]});
            foreach (payload[i]) sum = sum + payload[i];
        end
`ifdef BOOT_CHECKSUM_EN
        if (corrupt) exp_err = 1'b1;
`endif
        send_byte(n[7:0], max_gap);
        send_byte(n[15:8], max_gap);
        if (n <= MAXW) begin
            foreach (payload[i]) send_byte(payload[i], max_gap);
`ifdef BOOT_CHECKSUM_EN
            send_byte(corrupt ? sum + 8'h01 : sum, max_gap);
`endif
        end
        waited = 0;
        while (!(boot_done || boot_err) && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check_output({tag, "_finished"}, 32'(waited < 64), 32'd1);
        repeat (2) @(negedge clk);
        check_output({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_data.size()));
        foreach (exp_data[i]) begin
            if (i < obs_addr.size()) begin
                check_output($sformatf("%s_addr%0d", tag, i), obs_addr[i], 32'(i));
                check_output($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
            end
        end
        check_output({tag, "_done"}, 32'(boot_done), 32'(!exp_err));
        check_output({tag, "_err"}, 32'(boot_err), 32'(exp_err));
        check_output({tag, "_bootloading"}, 32'(bootloading), 32'(exp_err));
    endtask

    initial begin
        logic [7:0] pl[$];
        int         n;
        $display("[TB] boot_ctrl bench start, ADDRIW=%0d", ADDRIW);

        // Reset state.
        repeat (2) @(negedge clk);
        check_output("rst_bootloading_held", 32'(bootloading), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_bootloading", 32'(bootloading), 32'd1);
        check_output("rst_done", 32'(boot_done), 32'd0);
        check_output("rst_err", 32'(boot_err), 32'd0);
        check_output("rst_we", 32'(we_boot), 32'd0);
        check_output("rst_addr", 32'(wdata_addr), 32'd0);
        check_output("rst_data", wdata_data, 32'd0);

        // Directed two-word image.
        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        do_load("two_words", 2, pl, 1'b0, 0);

        // Restart with a coincident byte that must be dropped.
        restart("req_with_byte", 1'b1);
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
        do_load("after_drop", 3, pl, 1'b0, 1);

        // Zero-length load.
        restart("req_zero", 1'b0);
        pl.delete();
        do_load("zero_len", 0, pl, 1'b0, 0);

        // Oversized load, then bytes in ERR are ignored.
        restart("req_big", 1'b0);
        do_load("len_ffff", 16'hFFFF, pl, 1'b0, 0);
        obs_addr.delete();
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 0);
        repeat (2) @(negedge clk);
        check_output("err_ignore_rx_writes", 32'(obs_addr.size()), 32'd0);
        check_output("err_ignore_rx_err", 32'(boot_err), 32'd1);
        restart("req_from_err", 1'b0);

        // Just over and exactly at the memory size.
        do_load("len_max_plus1", MAXW + 1, pl, 1'b0, 0);
        restart("req_max", 1'b0);
        for (int i = 0; i < 4 * MAXW; i++) pl.push_back(8'($urandom));
        do_load("len_max", MAXW, pl, 1'b0, 0);

        // Reset in the middle of a word, then a fresh single-word load.
        restart("req_midrst", 1'b0);
        obs_addr.delete();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hDD, 0);
        send_byte(8'hCC, 0);
        #1 rst = 1'b1;
        #2;
        check_output("midrst_bootloading", 32'(bootloading), 32'd1);
        check_output("midrst_addr", 32'(wdata_addr), 32'd0);
        check_output("midrst_data", wdata_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("midrst_nowrite", 32'(obs_addr.size()), 32'd0);
        pl = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        do_load("after_midrst", 1, pl, 1'b0, 0);

`ifdef BOOT_CHECKSUM_EN
        // Checksum match and mismatch on a fixed word.
        restart("req_chk_ok", 1'b0);
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load("chk_0a", 1, pl, 1'b0, 2);
        restart("req_chk_bad", 1'b0);
        do_load("chk_0b", 1, pl, 1'b1, 2);
        restart("req_after_chk_err", 1'b0);
        pl.delete();
        do_load("chk_reload_zero", 0, pl, 1'b0, 0);
`endif

        // Randomised loads with random gaps and optional coincident bytes.
        for (int k = 0; k < 6; k++) begin
            restart($sformatf("req_rand%0d", k), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) restart($sformatf("req_ignored%0d", k), 1'b0);
            n = $urandom_range(1, 6);
            pl.delete();
            for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
            do_load($sformatf("rand%0d", k), n, pl, 1'($urandom_range(0, 3) == 0), 2);
        end

        check_output("we_never_double", 32'(we_double), 32'd0);
        check_output("we_never_after_load", 32'(we_outside), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
